ahbram_rst_seq: RTL and testbench

- Parametrised reset sequencer that drives staged, active-low reset outputs to NUM_CH downstream channels (AHB-RAM banks, bus bridge, monitors).
- Replaces the fixed "wait, assert N clocks, release" bench sequencing with synthesizable RTL.
- Adds a power-on settle delay, a programmable assert width, and staggered per-channel release.
- Adds a software-requested masked reset with a req/ack handshake.

---
 rtl/ahbram_rst_pkg.sv | 16 +
 rtl/ahbram_rst_cnt.sv | 29 ++
 rtl/ahbram_rst_seq.sv | 138 +++++++++++++
 tb/tb_ahbram_rst_seq.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/ahbram_rst_pkg.sv
// ahbram_rst_pkg: shared state encoding, default parameters and index-width helper for the reset sequencer
package ahbram_rst_pkg;

    typedef enum logic [1:0] {POR_WAIT, ASSERT, RELEASE, IDLE} rst_state_e;

    localparam int DEF_NUM_CH    = 4;
    localparam int DEF_CNT_W     = 8;
    localparam int DEF_POR_DLY   = 10;
    localparam int DEF_HOLD_CYC  = 5;
    localparam int DEF_STAGE_GAP = 1;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ahbram_rst_cnt.sv
// ahbram_rst_cnt: up/down phase counter with load, enable and terminal-count compare
module ahbram_rst_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_i,
    input  logic [CNT_W-1:0] ld_val_i,
    input  logic             en_i,
    input  logic             dn_i,
    input  logic [CNT_W-1:0] tc_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;

    // load has priority over counting; direction selectable per cycle
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (ld_i)
            cnt_q <= ld_val_i;
        else if (en_i)
            cnt_q <= dn_i ? cnt_q - CNT_W'(1) : cnt_q + CNT_W'(1);
    end

    assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/ahbram_rst_seq.sv
// ahbram_rst_seq: staged active-low reset sequencer with power-on settle and software-requested masked reset
module ahbram_rst_seq
    import ahbram_rst_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int POR_DLY   = DEF_POR_DLY,
    parameter int DEF_HOLD  = DEF_HOLD_CYC,
    parameter int STAGE_GAP = DEF_STAGE_GAP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sw_req,
    input  logic [CNT_W-1:0]  sw_hold,
    input  logic [NUM_CH-1:0] sw_mask,
    output logic              sw_ack,
    output logic [NUM_CH-1:0] rstn_out,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = idx_w(NUM_CH);
    localparam logic [CNT_W-1:0] POR_TC   = CNT_W'(POR_DLY - 1);
    localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] HOLD_DEF = CNT_W'(DEF_HOLD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("NUM_CH must be in 1..16");
    end
    if (POR_DLY < 1 || POR_DLY >= (1 << CNT_W)) begin : g_bad_por_dly
        $error("POR_DLY must be >=1 and fit in CNT_W");
    end
    if (DEF_HOLD < 1 || DEF_HOLD >= (1 << CNT_W)) begin : g_bad_def_hold
        $error("DEF_HOLD must be >=1 and fit in CNT_W");
    end
    if (STAGE_GAP < 1 || STAGE_GAP >= (1 << CNT_W)) begin : g_bad_stage_gap
        $error("STAGE_GAP must be >=1 and fit in CNT_W");
    end

    rst_state_e        state_q, state_d;
    logic [NUM_CH-1:0] rstn_q, rstn_d, mask_q, mask_d;
    logic [CNT_W-1:0]  hold_q, hold_d, tc_val;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              ack_q, ack_d, done_q, done_d, busy_q, busy_d;
    logic              cnt_ld, cnt_en, cnt_tc;

    // one counter serves every phase; only its terminal value changes with state
    ahbram_rst_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .ld_i     (cnt_ld),
        .ld_val_i ('0),
        .en_i     (cnt_en),
        .dn_i     (1'b0),
        .tc_val_i (tc_val),
        .tc_o     (cnt_tc)
    );

    // next-state, counter control and registered-output values
    always_comb begin
        state_d = state_q;
        rstn_d  = rstn_q;
        mask_d  = mask_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        ack_d   = 1'b0;
        done_d  = 1'b0;
        cnt_ld  = 1'b0;
        cnt_en  = 1'b0;
        tc_val  = POR_TC;
        case (state_q)
            POR_WAIT: begin
                cnt_ld  = cnt_tc;
                cnt_en  = !cnt_tc;
                state_d = cnt_tc ? ASSERT : POR_WAIT;
            end
            ASSERT: begin
                tc_val  = hold_q - CNT_W'(1);
                cnt_ld  = cnt_tc;
                cnt_en  = !cnt_tc;
                idx_d   = cnt_tc ? '0 : idx_q;
                state_d = cnt_tc ? RELEASE : ASSERT;
            end
            RELEASE: begin
                tc_val = GAP_TC;
                cnt_ld = cnt_tc;
                cnt_en = !cnt_tc;
                if (cnt_tc) begin
                    rstn_d[idx_q] = rstn_q[idx_q] | mask_q[idx_q];
                    idx_d         = idx_q + IDX_W'(1);
                    done_d        = (idx_q == IDX_LAST);
                    state_d       = (idx_q == IDX_LAST) ? IDLE : RELEASE;
                end
            end
            default: begin
                if (sw_req) begin
                    mask_d  = sw_mask;
                    hold_d  = (sw_hold == '0) ? HOLD_DEF : sw_hold;
                    ack_d   = 1'b1;
                    rstn_d  = rstn_q & ~sw_mask;
                    cnt_ld  = 1'b1;
                    state_d = ASSERT;
                end
            end
        endcase
        busy_d = (state_d != IDLE) || done_d;
    end

    // state and output registers, all forced to power-on values by rst
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= POR_WAIT;
            rstn_q  <= '0;
            mask_q  <= '1;
            hold_q  <= HOLD_DEF;
            idx_q   <= '0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            rstn_q  <= rstn_d;
            mask_q  <= mask_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign sw_ack   = ack_q;
    assign rstn_out = rstn_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_ahbram_rst_seq.sv
// tb_ahbram_rst_seq: directed checks of power-on, software, back-to-back and mid-sequence reset behaviour
module tb_ahbram_rst_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw_req = 1'b0;
    logic       sw_req2 = 1'b0;
    logic [7:0] sw_hold = '0;
    logic [3:0] sw_mask = '0;
    logic [7:0] sw_mask2 = '0;
    logic       sw_ack, busy, done, sw_ack2, busy2, done2;
    logic [3:0] rstn_out;
    logic [7:0] rstn_out2;
    logic [3:0] e4;
    logic [7:0] e8;
    int         tests = 0;
    int         fails = 0;
    int         acks;

    always #5 clk = ~clk;

    ahbram_rst_seq dut (
        .clk(clk), .rst(rst), .sw_req(sw_req), .sw_hold(sw_hold), .sw_mask(sw_mask),
        .sw_ack(sw_ack), .rstn_out(rstn_out), .busy(busy), .done(done)
    );

    ahbram_rst_seq #(.NUM_CH(8), .STAGE_GAP(3)) dut8 (
        .clk(clk), .rst(rst), .sw_req(sw_req2), .sw_hold(sw_hold), .sw_mask(sw_mask2),
        .sw_ack(sw_ack2), .rstn_out(rstn_out2), .busy(busy2), .done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_por(input int k);
        e4 = '0;
        for (int i = 0; i < 4; i++) if (k >= 16 + i) e4[i] = 1'b1;
        chk("por_rstn", rstn_out, e4);
        chk("por_done", done, k == 19);
        chk("por_busy", busy, k <= 19);
        chk("por_ack", sw_ack, 0);
    endtask

    initial begin
        repeat (3) step();
        chk("rst_rstn", rstn_out, 4'b0000);
        chk("rst_busy", busy, 1);
        chk("rst_ack", sw_ack, 0);
        chk("rst_done", done, 0);
        chk("rst_rstn8", rstn_out2, 8'h00);
        rst = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k <= 20) check_por(k);
            e8 = '0;
            for (int i = 0; i < 8; i++) if (k >= 15 + 3 * (i + 1)) e8[i] = 1'b1;
            chk("gap3_rstn", rstn_out2, e8);
            chk("gap3_done", done2, k == 39);
            chk("gap3_busy", busy2, k <= 39);
        end

        sw_mask = 4'b0101;
        sw_hold = 8'd3;
        sw_req  = 1'b1;
        step();
        sw_req = 1'b0;
        chk("sw_ack", sw_ack, 1);
        chk("sw_rstn0", rstn_out, 4'b1010);
        chk("sw_busy0", busy, 1);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("sw_rstn", rstn_out, k <= 3 ? 4'b1010 : (k <= 5 ? 4'b1011 : 4'b1111));
            chk("sw_ack_low", sw_ack, 0);
            chk("sw_done", done, k == 7);
            chk("sw_busy", busy, k <= 7);
        end

        sw_mask = 4'b1111;
        sw_hold = 8'd0;
        sw_req  = 1'b1;
        step();
        sw_req = 1'b0;
        chk("def_ack", sw_ack, 1);
        chk("def_rstn0", rstn_out, 4'b0000);
        for (int k = 1; k <= 10; k++) begin
            step();
            e4 = '0;
            for (int i = 0; i < 4; i++) if (k >= 6 + i) e4[i] = 1'b1;
            chk("def_rstn", rstn_out, e4);
            chk("def_done", done, k == 9);
            chk("def_busy", busy, k <= 9);
        end

        sw_hold = 8'd1;
        sw_req  = 1'b1;
        acks    = 0;
        for (int k = 0; k <= 6; k++) begin
            step();
            if (sw_ack) acks++;
            chk("held_ack", sw_ack, k == 0 || k == 6);
        end
        chk("held_ack_total", acks, 2);
        sw_req = 1'b0;
        for (int k = 7; k <= 12; k++) begin
            step();
            chk("held_done", done, k == 11);
            chk("held_busy", busy, k <= 11);
        end

        sw_req = 1'b1;
        step();
        sw_req = 1'b0;
        repeat (3) step();
        chk("mid_rstn_pre", rstn_out, 4'b0011);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rstn", rstn_out, 4'b0000);
        chk("mid_busy", busy, 1);
        chk("mid_done", done, 0);
        for (int k = 1; k <= 20; k++) begin
            step();
            check_por(k);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
